// File: rtl/mem_stage.sv
// mem_stage: memory-access/write-back stage; return-address stack enabled by MEM_STAGE_RAS_EN
module mem_stage #(
    parameter int RAS_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] ALU_IN,
    input  logic [4:0]  OPCD_IN,
    input  logic [4:0]  ADDR_REG_IN,
    input  logic        COND_IN,
    input  logic [15:0] NPC_IN,
    input  logic [15:0] STORE_DATA,
    output logic [15:0] DMEM_ADDR,
    output logic [15:0] DMEM_WDATA,
    output logic        DMEM_RE,
    output logic        DMEM_WE,
    input  logic [15:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        WB_EN,
    output logic [4:0]  WB_ADDR,
    output logic [15:0] WB_DATA,
    output logic        PC_LOAD,
    output logic [15:0] PC_TARGET,
    output logic        RAS_ERR,
    output logic [2:0]  ESTADO
);
    localparam logic [2:0] S_IDLE = 3'd0, S_RD = 3'd1, S_WR = 3'd2, S_WB = 3'd3, S_RDIR = 3'd4;
    localparam logic [4:0] OP_LW = 5'd0, OP_SW = 5'd1, OP_CMP = 5'd8, OP_JR = 5'd10;
    localparam logic [4:0] OP_JPC = 5'd11, OP_BRLF = 5'd12, OP_CALL = 5'd13, OP_RET = 5'd14;

    logic [2:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d, pc_q, pc_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        err_q, err_d;
    logic        accept, is_alu, is_jmp, is_call, is_ret, ras_empty;
    logic [15:0] ras_top;
    logic        unused_hi;

    assign accept    = IN_VALID && (state_q == S_IDLE);
    assign is_alu    = (OPCD_IN >= 5'd2) && (OPCD_IN <= 5'd9) && (OPCD_IN != OP_CMP);
    assign is_jmp    = (OPCD_IN inside {OP_JR, OP_JPC, OP_BRLF}) && COND_IN;
    assign is_call   = OPCD_IN == OP_CALL;
    assign unused_hi = ^ALU_IN[31:16];

`ifdef MEM_STAGE_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;
    logic [15:0]   ras_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic          push, pop;

    assign is_ret    = OPCD_IN == OP_RET;
    assign push      = accept && is_call;
    assign pop       = accept && is_ret && !ras_empty;
    assign ras_empty = cnt_q == '0;
    assign ras_top   = ras_empty ? 16'h0 : ras_q[ptr_q - PW'(1)];

    // Circular stack pointer and occupancy; a push when full silently replaces the oldest entry
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= push ? ptr_q + PW'(1) : pop ? ptr_q - PW'(1) : ptr_q;
            cnt_q <= push ? ((cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1)) : pop ? cnt_q - CW'(1) : cnt_q;
        end
    end

    // Stack storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge CLK) begin
        if (push) ras_q[ptr_q] <= NPC_IN;
    end
`else
    logic unused_ras;
    assign is_ret     = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_top    = 16'h0;
    assign unused_ras = ^{NPC_IN, 32'(RAS_DEPTH)};
`endif

    // Next state and the latched operands of the op in flight
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        pc_d      = pc_q;
        err_d     = err_q;
        if (accept) begin
            state_d   = (OPCD_IN == OP_LW) ? S_RD : (OPCD_IN == OP_SW) ? S_WR : is_alu ? S_WB :
                        (is_jmp || is_call || is_ret) ? S_RDIR : S_IDLE;
            addr_d    = (OPCD_IN == OP_LW || OPCD_IN == OP_SW) ? ALU_IN[15:0] : addr_q;
            wdata_d   = (OPCD_IN == OP_SW) ? STORE_DATA : wdata_q;
            wb_addr_d = ADDR_REG_IN;
            wb_data_d = ALU_IN[15:0];
            pc_d      = is_ret ? ras_top : ALU_IN[15:0];
            err_d     = is_ret && ras_empty;
        end else if (state_q == S_RD) begin
            state_d   = DMEM_ACK ? S_WB : S_RD;
            wb_data_d = DMEM_ACK ? DMEM_RDATA : wb_data_q;
        end else if (state_q == S_WR) begin
            state_d   = DMEM_ACK ? S_IDLE : S_WR;
        end else begin
            state_d   = S_IDLE;
        end
    end

    // State and operand registers; reset drops any outstanding memory request
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            pc_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
        end
    end

    assign IN_READY   = state_q == S_IDLE;
    assign DMEM_RE    = state_q == S_RD;
    assign DMEM_WE    = state_q == S_WR;
    assign WB_EN      = state_q == S_WB;
    assign PC_LOAD    = state_q == S_RDIR;
    assign RAS_ERR    = PC_LOAD && err_q;
    assign DMEM_ADDR  = addr_q;
    assign DMEM_WDATA = wdata_q;
    assign WB_ADDR    = wb_addr_q;
    assign WB_DATA    = wb_data_q;
    assign PC_TARGET  = pc_q;
    assign ESTADO     = state_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; RAS checks follow MEM_STAGE_RAS_EN
module tb_mem_stage;
    localparam int D = 4;

    logic        clk = 0;
    logic        RST = 0;
    logic        IN_VALID = 0;
    logic        IN_READY;
    logic [31:0] ALU_IN = 0;
    logic [4:0]  OPCD_IN = 0, ADDR_REG_IN = 0;
    logic        COND_IN = 0;
    logic [15:0] NPC_IN = 0, STORE_DATA = 0;
    logic [15:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic        DMEM_RE, DMEM_WE, DMEM_ACK;
    logic        WB_EN, PC_LOAD, RAS_ERR;
    logic [4:0]  WB_ADDR;
    logic [15:0] WB_DATA, PC_TARGET;
    logic [2:0]  ESTADO;

    logic        auto_ack = 1, m_ack = 0, r_ack = 0;
    logic [15:0] r_rdata = 0;
    int          wcnt = 0, fix_lat = -1, re_cyc = 0, we_cyc = 0;
    int          ncmp = 0, nfail = 0;

    typedef struct { int k; logic [15:0] a; logic [15:0] d; logic e; } exp_t;
    exp_t        sb[$];
    logic [15:0] stk[$];
    logic [15:0] mmem [logic [15:0]];
    logic [15:0] rmem [logic [15:0]];

    assign DMEM_ACK   = auto_ack ? r_ack : m_ack;
    assign DMEM_RDATA = r_rdata;

    always #5 clk = ~clk;

    mem_stage #(.RAS_DEPTH(D)) dut (
        .CLK(clk), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ALU_IN(ALU_IN),
        .OPCD_IN(OPCD_IN), .ADDR_REG_IN(ADDR_REG_IN), .COND_IN(COND_IN), .NPC_IN(NPC_IN),
        .STORE_DATA(STORE_DATA), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_RE(DMEM_RE), .DMEM_WE(DMEM_WE), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
        .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .PC_LOAD(PC_LOAD),
        .PC_TARGET(PC_TARGET), .RAS_ERR(RAS_ERR), .ESTADO(ESTADO)
    );

    function automatic logic [15:0] mget(input logic [15:0] a);
        return mmem.exists(a) ? mmem[a] : (a ^ 16'hA5C3);
    endfunction

    function automatic logic [15:0] rget(input logic [15:0] a);
        return rmem.exists(a) ? rmem[a] : (a ^ 16'hA5C3);
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h required %h", n, act, exp);
        end
    endtask

    task automatic sb_chk(input int k, input logic [15:0] a, input logic [15:0] d, input logic e);
        exp_t x;
        if (sb.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL unexpected_output: kind %0d a=%h d=%h with nothing required", k, a, d);
        end else begin
            x = sb.pop_front();
            chk("out_kind", 32'(k), 32'(x.k));
            chk(k == 1 ? "pc_target" : k == 0 ? "wb_addr" : "st_addr", {16'h0, a}, {16'h0, x.a});
            if (k == 1) chk("ras_err", {31'h0, e}, {31'h0, x.e});
            else chk(k == 0 ? "wb_data" : "st_data", {16'h0, d}, {16'h0, x.d});
        end
    endtask

    // Reference model: what the stage must eventually emit for one accepted op
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [4:0] r,
                         input logic c, input logic [15:0] npc, input logic [15:0] sd);
        if (op == 0) sb.push_back('{0, {11'h0, r}, mget(a[15:0]), 1'b0});
        else if (op == 1) begin
            sb.push_back('{2, a[15:0], sd, 1'b0});
            mmem[a[15:0]] = sd;
        end else if (op >= 2 && op <= 9 && op != 8) sb.push_back('{0, {11'h0, r}, a[15:0], 1'b0});
        else if (op >= 10 && op <= 12) begin
            if (c) sb.push_back('{1, a[15:0], 16'h0, 1'b0});
        end else if (op == 13) begin
`ifdef MEM_STAGE_RAS_EN
            stk.push_back(npc);
            if (stk.size() > D) void'(stk.pop_front());
`endif
            sb.push_back('{1, a[15:0], 16'h0, 1'b0});
        end else if (op == 14) begin
`ifdef MEM_STAGE_RAS_EN
            if (stk.size() == 0) sb.push_back('{1, 16'h0, 16'h0, 1'b1});
            else sb.push_back('{1, stk.pop_back(), 16'h0, 1'b0});
`endif
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [4:0] r,
                         input logic c, input logic [15:0] npc, input logic [15:0] sd);
        int n = 0;
        @(negedge clk);
        while (!IN_READY) begin
            n++;
            if (n > 200) begin
                ncmp++;
                nfail++;
                $display("FAIL issue_timeout: IN_READY 0 for 200 cycles, required 1");
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
                $finish;
            end
            IN_VALID = 1'($urandom);
            OPCD_IN = 5'($urandom);
            ALU_IN = $urandom;
            COND_IN = 1'($urandom);
            @(negedge clk);
        end
        model(op, a, r, c, npc, sd);
        IN_VALID = 1;
        OPCD_IN = op;
        ALU_IN = a;
        ADDR_REG_IN = r;
        COND_IN = c;
        NPC_IN = npc;
        STORE_DATA = sd;
        @(posedge clk);
        #1 IN_VALID = 0;
    endtask

    // Memory responder: programmable ack latency, spurious acks while no request is pending
    always @(posedge clk) begin
        #2;
        if (DMEM_RE) re_cyc++;
        if (DMEM_WE) we_cyc++;
        if (!auto_ack) r_ack = 0;
        else if (DMEM_RE || DMEM_WE) begin
            if (wcnt == 0) begin
                r_ack = 1;
                if (DMEM_RE) r_rdata = rget(DMEM_ADDR);
                else rmem[DMEM_ADDR] = DMEM_WDATA;
            end else begin
                wcnt--;
                r_ack = 0;
                r_rdata = 16'($urandom);
            end
        end else begin
            r_ack = ($urandom_range(0, 3) == 0);
            r_rdata = 16'($urandom);
            wcnt = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
        end
    end

    // Monitor: every pulse and every acknowledged store is matched against the scoreboard
    always @(negedge clk) begin
        if (RST) begin
            if (WB_EN || PC_LOAD || RAS_ERR) chk("pulse_vs_dmem", {31'h0, DMEM_RE | DMEM_WE}, 0);
            if (RAS_ERR) chk("ras_err_without_pc_load", {31'h0, PC_LOAD}, 1);
            if (WB_EN) sb_chk(0, {11'h0, WB_ADDR}, WB_DATA, 1'b0);
            if (PC_LOAD) sb_chk(1, PC_TARGET, 16'h0, RAS_ERR);
            if (DMEM_WE && DMEM_ACK) sb_chk(2, DMEM_ADDR, DMEM_WDATA, 1'b0);
        end
    end

    initial begin
        int re0, we0, n;
        logic [15:0] ret_exp [4];
        logic [4:0] op;
        logic [31:0] a;
        ret_exp[0] = 16'h15; ret_exp[1] = 16'h14; ret_exp[2] = 16'h13; ret_exp[3] = 16'h12;
        mmem[16'h0010] = 16'hBEEF;
        rmem[16'h0010] = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'h0, IN_READY}, 1);
        chk("reset_estado", {29'h0, ESTADO}, 0);
        chk("reset_pulses", {29'h0, WB_EN, PC_LOAD, RAS_ERR}, 0);
        RST = 1;

        // Reset while a load is waiting for its ack
        auto_ack = 0;
        @(negedge clk);
        IN_VALID = 1; OPCD_IN = 5'd0; ALU_IN = 32'h0000_0040; ADDR_REG_IN = 5'd3;
        @(posedge clk);
        #1 IN_VALID = 0;
        @(negedge clk);
        chk("rd_wait_re", {31'h0, DMEM_RE}, 1);
        chk("rd_wait_addr", {16'h0, DMEM_ADDR}, 32'h40);
        #2 RST = 0;
        #1;
        chk("async_reset_ready", {31'h0, IN_READY}, 1);
        chk("async_reset_outs", {DMEM_ADDR, 11'h0, DMEM_RE, DMEM_WE, WB_EN, PC_LOAD, RAS_ERR}, 0);
        chk("async_reset_estado", {29'h0, ESTADO}, 0);
        @(negedge clk);
        RST = 1;
        m_ack = 1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_ignored", {28'h0, ESTADO, WB_EN}, 0);
        end
        m_ack = 0;
        auto_ack = 1;

        // ALU write-back latency and truncation
        issue(5'd2, 32'h0001_1234, 5'd5, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("add_wb_en", {31'h0, WB_EN}, 1);
        chk("add_wb", {11'h0, WB_ADDR, WB_DATA}, {11'h0, 5'd5, 16'h1234});
        @(negedge clk);
        chk("add_one_cycle", {31'h0, WB_EN}, 0);

        // Load acked in its third wait cycle
        fix_lat = 2;
        re0 = re_cyc;
        issue(5'd0, 32'h0000_0010, 5'd7, 1'b0, 16'h0, 16'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!WB_EN && n < 20);
        chk("lw_wb_en", {31'h0, WB_EN}, 1);
        chk("lw_re_cycles", 32'(re_cyc - re0), 3);
        chk("lw_data", {16'h0, WB_DATA}, 32'hBEEF);

        // Store acked in its first cycle
        fix_lat = 0;
        we0 = we_cyc;
        issue(5'd1, 32'h0000_0020, 5'd0, 1'b0, 16'h0, 16'h5A5A);
        @(negedge clk);
        chk("sw_we", {31'h0, DMEM_WE}, 1);
        @(negedge clk);
        chk("sw_we_cycles", 32'(we_cyc - we0), 1);
        chk("sw_no_wb", {31'h0, WB_EN}, 0);
        fix_lat = -1;

        // Untaken and taken branches
        issue(5'd12, 32'h0000_0300, 5'd0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("brlf_untaken", {30'h0, PC_LOAD, IN_READY}, 1);
        issue(5'd11, 32'h0000_0100, 5'd0, 1'b1, 16'h0, 16'h0);
        @(negedge clk);
        chk("jpc_taken", {15'h0, PC_LOAD, PC_TARGET}, {15'h0, 1'b1, 16'h0100});

`ifdef MEM_STAGE_RAS_EN
        for (int i = 0; i < 5; i++) issue(5'd13, 32'h1000 + i, 5'd0, 1'b0, 16'h11 + 16'(i), 16'h0);
        for (int i = 0; i < 4; i++) begin
            issue(5'd14, 32'h0, 5'd0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            chk("ret_target", {14'h0, PC_LOAD, RAS_ERR, PC_TARGET}, {14'h0, 2'b10, ret_exp[i]});
        end
        issue(5'd14, 32'h0, 5'd0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("ret_empty", {14'h0, PC_LOAD, RAS_ERR, PC_TARGET}, {14'h0, 2'b11, 16'h0});
`else
        issue(5'd13, 32'h0000_0200, 5'd0, 1'b0, 16'h77, 16'h0);
        @(negedge clk);
        chk("call_jump", {15'h0, PC_LOAD, PC_TARGET}, {15'h0, 1'b1, 16'h0200});
        issue(5'd14, 32'h0, 5'd0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("ret_nop", {30'h0, PC_LOAD, RAS_ERR}, 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 19));
            op = (n > 15) ? 5'($urandom_range(16, 31)) : 5'(n);
            a = $urandom;
            if (op <= 1) a[15:0] = 16'($urandom_range(0, 7));
            issue(op, a, 5'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 1)) begin
                @(negedge clk);
                IN_VALID = 0;
            end
        end

        n = 0;
        while ((sb.size() != 0 || !IN_READY) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access/write-back stage directly downstream of the execute stage. It accepts one executed instruction at a time, runs LW/SW against a handshaked data memory, and produces one-cycle register write-back and PC-redirect pulses for ALU, jump, branch and call/return ops. It also maintains an optional return-address stack for CALL/RET. Opcode encoding is the core's 5-bit set: LW=00000, SW=00001, ADD..NOT=00010..01001 (CMP=01000), JR=01010, JPC=01011, BRLF=01100, CALL=01101, RET=01110, NOP=01111.

## Interface
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16)
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  executed instruction present
- IN_READY  out  1  stage can accept; high only in IDLE
- ALU_IN  in  32  execute result; bits [15:0] used
- OPCD_IN  in  5  opcode
- ADDR_REG_IN  in  5  destination register
- COND_IN  in  1  branch/jump taken
- NPC_IN  in  16  next sequential PC (return address for CALL)
- STORE_DATA  in  16  SW store value
- DMEM_ADDR  out  16  data-memory address
- DMEM_WDATA  out  16  store data
- DMEM_RE / DMEM_WE  out  1 each  read/write request, held until ack
- DMEM_RDATA  in  16  read data, valid with DMEM_ACK
- DMEM_ACK  in  1  request complete
- WB_EN  out  1  write-back pulse; WB_ADDR out 5; WB_DATA out 16
- PC_LOAD  out  1  redirect pulse; PC_TARGET out 16
- RAS_ERR  out  1  pulse on RET with empty stack
- ESTADO  out  3  current state (debug)

## Operation
- Transfer: IN_VALID && IN_READY at a rising edge latches all inputs. IN_VALID is ignored outside IDLE. Upstream holds its data until accepted.
- States (ESTADO): IDLE=0, RD_WAIT=1, WR_WAIT=2, WRITEBACK=3, REDIRECT=4.
- From IDLE on transfer:
  - LW → RD_WAIT with DMEM_ADDR=ALU_IN[15:0].
  - SW → WR_WAIT with DMEM_ADDR=ALU_IN[15:0] and DMEM_WDATA=STORE_DATA.
  - ADD, SUB, MUL, DIV, AND, OR, NOT → WRITEBACK with WB_DATA=ALU_IN[15:0]. MUL is truncated, no flag.
  - CMP, NOP → stay IDLE, no outputs.
  - JR, JPC, BRLF with COND_IN=1 → REDIRECT, PC_TARGET=ALU_IN[15:0]. With COND_IN=0 → stay IDLE.
  - CALL → push latched NPC_IN, REDIRECT to ALU_IN[15:0].
  - RET → pop, REDIRECT to popped value.
- RD_WAIT: DMEM_RE=1 every cycle. On DMEM_ACK, capture DMEM_RDATA into WB_DATA and go to WRITEBACK. ACK in the first RD_WAIT cycle is legal.
- WR_WAIT: DMEM_WE=1 every cycle. On DMEM_ACK → IDLE.
- WRITEBACK: WB_EN=1 for exactly one cycle with WB_ADDR/WB_DATA, then → IDLE.
- REDIRECT: PC_LOAD=1 for exactly one cycle with PC_TARGET, then → IDLE.
- RAS, circular, with an occupancy count:
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty gives PC_TARGET=0, a RAS_ERR pulse in the REDIRECT cycle, and PC_LOAD still asserted.
- DMEM_ACK outside RD_WAIT/WR_WAIT is ignored.

## Timing
- Reset (asynchronous, any state):
  - State → IDLE, RAS emptied.
  - All outputs 0 except IN_READY=1.
  - An outstanding DMEM request is dropped; its later ACK is ignored.
- Latency:
  - ALU op accepted at edge N → WB_EN high in cycle N+1.
  - Taken jump accepted at N → PC_LOAD high in cycle N+1.
  - LW whose ACK is sampled at edge K → WB_EN high in cycle K+1.
- Throughput: IN_READY low from the edge after acceptance until the op completes. Next accept is possible at the edge ending the WRITEBACK/REDIRECT/WR_WAIT-ack cycle. Non-writing ops (CMP, NOP, untaken branch) sustain 1 op/cycle.
- WB_EN, PC_LOAD and RAS_ERR are never high in the same cycle as DMEM_RE/DMEM_WE.

## Configuration
- MEM_STAGE_RAS_EN defined: RAS present as above.
- Undefined:
  - No RAS storage.
  - CALL behaves as an unconditional jump to ALU_IN[15:0], no push.
  - RET behaves as NOP, no PC_LOAD.
  - RAS_ERR tied 0.

## Test plan
- Reset mid-RD_WAIT (LW to 0x0040, no ACK), assert RST=0 → outputs 0, IN_READY=1. A later ACK is ignored and WB_EN stays 0.
- ADD with ALU_IN=0x0001_1234, ADDR_REG_IN=5 → one-cycle WB_EN, WB_ADDR=5, WB_DATA=0x1234, in cycle N+1.
- LW to 0x0010, ACK after 3 wait cycles with RDATA=0xBEEF → DMEM_RE held 3 cycles, then WB_EN with 0xBEEF. SW 0x0020←0x5A5A with same-cycle ACK → one DMEM_WE cycle, no WB_EN.
- BRLF with COND_IN=0 → no PC_LOAD, IN_READY stays 1. JPC to 0x0100 with COND_IN=1 → PC_LOAD, PC_TARGET=0x0100.
- With MEM_STAGE_RAS_EN, RAS_DEPTH=4:
  - Five CALLs with NPC 0x11..0x15, then four RETs → targets 0x15, 0x14, 0x13, 0x12.
  - A fifth RET → PC_TARGET=0, RAS_ERR=1.
- Without the macro: CALL to 0x0200 → PC_LOAD 0x0200. RET → no PC_LOAD, RAS_ERR=0.
